// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution; on a mispredict it emits
// one registered fail/redirect pulse carrying the corrected predictor state.
module branch_resolve_queue #(
    parameter int DEPTH          = 4,
    parameter int BTB_WAY_NUM    = 4,
    parameter int LOCAL_WIDTH    = 4,
    parameter int B_PATTEN_WIDTH = 2,
    parameter int GLOBAL_WIDTH   = 8,
    parameter int G_PATTEN_WIDTH = 2
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic                                         push_vld,
    input  logic [31:0]                                  push_pc,
    input  logic [BTB_WAY_NUM-1:0]                       push_way_vec,
    input  logic                                         push_taken,
    input  logic [31:0]                                  push_target,
    input  logic [LOCAL_WIDTH-1:0]                       push_history,
    input  logic [B_PATTEN_WIDTH*(2**LOCAL_WIDTH)-1:0]   push_patten_tab,
    input  logic [GLOBAL_WIDTH-1:0]                      push_ghr,
    input  logic [G_PATTEN_WIDTH-1:0]                    push_ghr_patten,
    output logic                                         push_rdy,
    input  logic                                         rslv_vld,
    input  logic                                         rslv_is_branch,
    input  logic                                         rslv_taken,
    input  logic [31:0]                                  rslv_target,
    output logic                                         rslv_rdy,
    input  logic                                         flush,
    output logic                                         fail,
    output logic [31:0]                                  fail_branch,
    output logic [BTB_WAY_NUM-1:0]                       fail_way_vec,
    output logic [31:0]                                  fill_target,
    output logic [LOCAL_WIDTH-1:0]                       fill_pht_history,
    output logic [B_PATTEN_WIDTH*(2**LOCAL_WIDTH)-1:0]   fill_pht_patten_tab,
    output logic [GLOBAL_WIDTH-1:0]                      fail_ghr,
    output logic [GLOBAL_WIDTH-1:0]                      fill_ghr,
    output logic [G_PATTEN_WIDTH-1:0]                    fill_ghr_patten,
    output logic                                         redirect_vld,
    output logic [31:0]                                  redirect_pc,
    output logic [$clog2(DEPTH):0]                       count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int TAB_N = 2**LOCAL_WIDTH;
    localparam int TAB_W = B_PATTEN_WIDTH * TAB_N;

    logic [31:0]             pc_mem      [DEPTH];
    logic [BTB_WAY_NUM-1:0]  way_mem     [DEPTH];
    logic                    taken_mem   [DEPTH];
    logic [31:0]             target_mem  [DEPTH];
    logic [LOCAL_WIDTH-1:0]  hist_mem    [DEPTH];
    logic [TAB_W-1:0]        tab_mem     [DEPTH];
    logic [GLOBAL_WIDTH-1:0] ghr_mem     [DEPTH];
    logic [G_PATTEN_WIDTH-1:0] gp_mem    [DEPTH];

    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          full, empty, pop_fire, push_accept, res_taken, mispredict;

    logic [31:0]               head_pc, head_target;
    logic [BTB_WAY_NUM-1:0]    head_way;
    logic                      head_taken;
    logic [LOCAL_WIDTH-1:0]    head_hist;
    logic [TAB_W-1:0]          head_tab, tab_next;
    logic [GLOBAL_WIDTH-1:0]   head_ghr;
    logic [G_PATTEN_WIDTH-1:0] head_gp, gp_next;

    logic                      fail_reg, redirect_vld_reg;
    logic [31:0]               fail_branch_reg, fill_target_reg, redirect_pc_reg;
    logic [BTB_WAY_NUM-1:0]    fail_way_vec_reg;
    logic [LOCAL_WIDTH-1:0]    fill_hist_reg;
    logic [TAB_W-1:0]          fill_tab_reg;
    logic [GLOBAL_WIDTH-1:0]   fail_ghr_reg, fill_ghr_reg;
    logic [G_PATTEN_WIDTH-1:0] fill_gp_reg;

    assign rd_idx = rd_ptr_reg[AW-1:0];
    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign empty  = (rd_ptr_reg == wr_ptr_reg);
    assign full   = (rd_ptr_reg[AW] != wr_ptr_reg[AW]) && (rd_idx == wr_idx);
    assign count  = wr_ptr_reg - rd_ptr_reg;

    assign push_rdy = ~full;
    assign rslv_rdy = ~empty;

    assign head_pc     = pc_mem[rd_idx];
    assign head_way    = way_mem[rd_idx];
    assign head_taken  = taken_mem[rd_idx];
    assign head_target = target_mem[rd_idx];
    assign head_hist   = hist_mem[rd_idx];
    assign head_tab    = tab_mem[rd_idx];
    assign head_ghr    = ghr_mem[rd_idx];
    assign head_gp     = gp_mem[rd_idx];

    assign pop_fire   = rslv_vld & ~empty;
    assign res_taken  = rslv_is_branch & rslv_taken;
    assign mispredict = pop_fire &
                        ((rslv_is_branch & (rslv_taken != head_taken)) |
                         (res_taken & (rslv_target != head_target)) |
                         (~rslv_is_branch & head_taken));
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_accept = push_vld & (~full | pop_fire) & ~flush & ~mispredict;

    // Saturating update of the local counter selected by the head history.
    generate
        for (genvar gi = 0; gi < TAB_N; gi++) begin : g_pht
            logic [B_PATTEN_WIDTH-1:0] old_ctr, upd_ctr;
            assign old_ctr = head_tab[gi*B_PATTEN_WIDTH +: B_PATTEN_WIDTH];
            assign upd_ctr = res_taken ? ((&old_ctr) ? old_ctr : old_ctr + B_PATTEN_WIDTH'(1))
                                       : ((|old_ctr) ? old_ctr - B_PATTEN_WIDTH'(1) : old_ctr);
            assign tab_next[gi*B_PATTEN_WIDTH +: B_PATTEN_WIDTH] =
                (head_hist == LOCAL_WIDTH'(gi)) ? upd_ctr : old_ctr;
        end
    endgenerate

    assign gp_next = res_taken ? ((&head_gp) ? head_gp : head_gp + G_PATTEN_WIDTH'(1))
                               : ((|head_gp) ? head_gp - G_PATTEN_WIDTH'(1) : head_gp);

    always_ff @(posedge clk) begin
        if (push_accept) begin
            pc_mem[wr_idx]     <= push_pc;
            way_mem[wr_idx]    <= push_way_vec;
            taken_mem[wr_idx]  <= push_taken;
            target_mem[wr_idx] <= push_target;
            hist_mem[wr_idx]   <= push_history;
            tab_mem[wr_idx]    <= push_patten_tab;
            ghr_mem[wr_idx]    <= push_ghr;
            gp_mem[wr_idx]     <= push_ghr_patten;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            fail_reg         <= 1'b0;
            redirect_vld_reg <= 1'b0;
            fail_branch_reg  <= '0;
            fail_way_vec_reg <= '0;
            fill_target_reg  <= '0;
            fill_hist_reg    <= '0;
            fill_tab_reg     <= '0;
            fail_ghr_reg     <= '0;
            fill_ghr_reg     <= '0;
            fill_gp_reg      <= '0;
            redirect_pc_reg  <= '0;
        end else begin
            // Entries behind a mispredicted head are wrong-path, so both cases empty the queue.
            if (flush || mispredict) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else begin
                if (push_accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop_fire)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            fail_reg         <= mispredict;
            redirect_vld_reg <= mispredict;
            if (mispredict) begin
                fail_branch_reg  <= head_pc;
                fail_way_vec_reg <= head_way;
                fill_target_reg  <= res_taken ? rslv_target : head_target;
                fill_hist_reg    <= {head_hist[LOCAL_WIDTH-2:0], res_taken};
                fill_tab_reg     <= tab_next;
                fail_ghr_reg     <= head_ghr;
                fill_ghr_reg     <= {head_ghr[GLOBAL_WIDTH-2:0], res_taken};
                fill_gp_reg      <= gp_next;
                redirect_pc_reg  <= res_taken ? rslv_target : head_pc + 32'd8;
            end
        end
    end

    assign fail                = fail_reg;
    assign redirect_vld        = redirect_vld_reg;
    assign fail_branch         = fail_branch_reg;
    assign fail_way_vec        = fail_way_vec_reg;
    assign fill_target         = fill_target_reg;
    assign fill_pht_history    = fill_hist_reg;
    assign fill_pht_patten_tab = fill_tab_reg;
    assign fail_ghr            = fail_ghr_reg;
    assign fill_ghr            = fill_ghr_reg;
    assign fill_ghr_patten     = fill_gp_reg;
    assign redirect_pc         = redirect_pc_reg;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning): DEPTH, 4, number of queue entries, power of 2 and at least 2.
REQ-002 SHALL have parameter BTB_WAY_NUM, 4, number of BTB ways.
REQ-003 SHALL have parameter LOCAL_WIDTH, 4, local history width, at least 2.
REQ-004 SHALL have parameter B_PATTEN_WIDTH, 2, width of each local counter.
REQ-005 SHALL have parameters GLOBAL_WIDTH, 8, and G_PATTEN_WIDTH, 2, for the global history and the global counter.
REQ-006 SHALL have ports (name, direction, width, meaning): clk, in, 1, the single clock; resetn, in, 1, asynchronous active-low reset.
REQ-007 SHALL have push ports, all inputs: push_vld 1; push_pc 32; push_way_vec BTB_WAY_NUM; push_taken 1; push_target 32; push_history LOCAL_WIDTH; push_patten_tab B_PATTEN_WIDTH*2^LOCAL_WIDTH; push_ghr GLOBAL_WIDTH; push_ghr_patten G_PATTEN_WIDTH.
REQ-008 SHALL have output push_rdy, 1, which is high when the queue is not full.
REQ-009 SHALL have resolve inputs rslv_vld 1, rslv_is_branch 1, rslv_taken 1, rslv_target 32, and output rslv_rdy 1, which is high when the queue is not empty.
REQ-010 SHALL have input flush, 1, which discards all entries.
REQ-011 SHALL have outputs to the predictor: fail 1; fail_branch 32; fail_way_vec BTB_WAY_NUM; fill_target 32; fill_pht_history LOCAL_WIDTH; fill_pht_patten_tab B_PATTEN_WIDTH*2^LOCAL_WIDTH; fail_ghr GLOBAL_WIDTH; fill_ghr GLOBAL_WIDTH; fill_ghr_patten G_PATTEN_WIDTH.
REQ-012 SHALL have outputs redirect_vld 1 and redirect_pc 32, and output count of width log2(DEPTH)+1.

Function
REQ-013 SHALL store entries in a circular FIFO whose read and write pointers each carry one extra wrap bit: full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
REQ-014 SHALL accept a push when push_vld & push_rdy; a push while full is ignored.
REQ-015 SHALL pop the head entry when rslv_vld & rslv_rdy; a resolve while empty is ignored and produces no output.
REQ-016 SHALL allow a push and a pop in the same cycle, including when the queue is full; count is unchanged in that case.
REQ-017 SHALL detect a mispredict on each pop when any of the following holds:
- rslv_is_branch and rslv_taken differs from the head's taken bit;
- rslv_is_branch, rslv_taken, and rslv_target differs from the head target;
- !rslv_is_branch and the head's taken bit is 1.
REQ-018 SHALL, on a mispredict, assert fail and redirect_vld for exactly one cycle, registered one clock after the pop, with all fill and redirect fields held valid in that cycle.
REQ-019 SHALL drive fail_branch = head pc and fail_way_vec = head way_vec.
REQ-020 SHALL drive fill_target = rslv_target when resolved taken, otherwise the head target.
REQ-021 SHALL drive fill_pht_history = {head history[LOCAL_WIDTH-2:0], resolved taken}, where resolved taken = rslv_is_branch & rslv_taken.
REQ-022 SHALL drive fill_pht_patten_tab = the head table with only the entry indexed by head history updated by the saturating counter rule:
- +1 if resolved taken, -1 if not;
- clamps at 0 and at all-ones; every other entry unchanged.
REQ-023 SHALL drive fail_ghr = head ghr and fill_ghr = {head ghr[GLOBAL_WIDTH-2:0], resolved taken}; fill_ghr[0] = 0 therefore blocks the BTB write downstream.
REQ-024 SHALL drive fill_ghr_patten = head ghr_patten updated by the same saturating rule.
REQ-025 SHALL drive redirect_pc = rslv_target when resolved taken, otherwise head pc + 8 (past the delay slot), modulo 2^32.
REQ-026 SHALL, on a mispredict, empty the queue in the cycle of the pop (younger entries are wrong-path), with a concurrent push dropped.
REQ-027 SHALL, on flush, empty the queue at the next edge; flush overrides a concurrent push or pop, and a concurrent mispredict still registers fail.
REQ-028 SHALL, on a correct prediction, pop the entry with no fail and no redirect.

Reset
REQ-029 SHALL, when resetn is low, asynchronously clear both pointers, count, fail, redirect_vld and all registered fill and redirect fields to 0.
REQ-030 SHALL drive push_rdy = 1 and rslv_rdy = 0 after reset; entry storage need not be reset.
REQ-031 SHALL, when reset is asserted mid-operation, discard all entries and drop any pending fail pulse.

Verification
REQ-032 SHALL be verified with: push pc=0x100 taken=1 target=0x200, resolve taken=1 target=0x200 -> no fail, count 1->0.
REQ-033 SHALL be verified with: push pc=0x100 taken=0 history=4'b0101 with counter[5]=2'b01, resolve taken=1 target=0x300 -> next cycle fail=1, redirect_pc=0x300, fill_pht_history=4'b1011, counter[5]=2'b10, fill_ghr[0]=1.
REQ-034 SHALL be verified with: push pc=0x400 taken=1, resolve is_branch=0 -> fail=1, fill_ghr[0]=0, redirect_pc=0x408, counter decremented (floor 0).
REQ-035 SHALL be verified with: push DEPTH entries -> push_rdy=0; a further push is ignored; a simultaneous push and pop when full keeps count=DEPTH; then drain in order.
REQ-036 SHALL be verified with: 3 entries queued, mispredict on the head with a concurrent push -> count=0 next cycle and the pushed entry is absent.
REQ-037 SHALL be verified with: a counter at 2'b11 resolved taken -> it stays 2'b11; resetn pulsed low asynchronously mid-stream -> count=0 and fail=0 immediately.
